instruction_fetch: RTL

- Fetch stage of the MIPS pipeline; sits directly upstream of the instruction decoder and feeds it one 32-bit instruction at a time.
- Holds the PC and issues word reads to instruction memory over a request/grant/response interface, with one request outstanding at most.
- Presents each instruction with its PC to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from later stages and discards any in-flight stale fetch.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/instruction_fetch.sv | 88 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Definitions shared across the MIPS pipeline stages: fetch FSM encoding,
// PC constants and instruction field widths used by the decoder.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OUT   = 2'd2,
        DRAIN = 2'd3
    } fetchState_t;

    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load takes priority over the
// sequential increment; redirect targets are forced to word alignment.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Load,
    input  logic [31:0] LoadPC,
    input  logic        Advance,
    output logic [31:0] Pc
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            Pc <= RESET_PC;
        else if (Load)
            Pc <= alignWord(LoadPC);
        else if (Advance)
            Pc <= Pc + PC_STEP;   // wraps modulo 2^32 by construction
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: one outstanding instruction-memory read at a time,
// registered hand-off to the decoder, redirects discard stale fetches.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic [31:0] FetchCount
);

    fetchState_t state;
    logic [31:0] pc;
    logic        pcAdvance;

    // Only a clean response in WAIT moves the PC forward; redirects win.
    assign pcAdvance = (state == WAIT) && ImemRvalid && !Redirect;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) pcReg (
        .Clock   (Clock),
        .Reset   (Reset),
        .Load    (Redirect),
        .LoadPC  (RedirectPC),
        .Advance (pcAdvance),
        .Pc      (pc)
    );

    assign ImemReq  = (state == FETCH) && !Redirect && !Reset;
    assign ImemAddr = pc;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= FETCH;
            InstrValid  <= 1'b0;
            Instruction <= 32'd0;
            InstrPC     <= 32'd0;
            FetchCount  <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (!Redirect && ImemGnt)
                        state <= WAIT;
                end
                WAIT: begin
                    if (Redirect) begin
                        // A response landing with the redirect is simply dropped.
                        state <= ImemRvalid ? FETCH : DRAIN;
                    end else if (ImemRvalid) begin
                        Instruction <= ImemRdata;
                        InstrPC     <= pc;
                        InstrValid  <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (InstrValid && InstrReady)
                        FetchCount <= FetchCount + 32'd1;
                    if (Redirect || InstrReady) begin
                        InstrValid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (ImemRvalid)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
